// File: rtl/alu_issue_if.sv
// Instruction handshake and ALU operand/result bus between the issue
// controller (slave) and its environment (master: instruction source + ALU).
interface alu_issue_if;
    logic [17:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] alu_r1;
    logic [17:0] alu_r2;
    logic [1:0]  alu_op_type;
    logic [17:0] alu_result;
    logic        alu_cout;

    modport master (
        output instr, instr_valid, alu_result, alu_cout,
        input  instr_ready, alu_r1, alu_r2, alu_op_type
    );

    modport slave (
        input  instr, instr_valid, alu_result, alu_cout,
        output instr_ready, alu_r1, alu_r2, alu_op_type
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue/writeback sequencer in front of a combinational 18-bit ALU.
// Accepts one instruction per handshake, reads two operands from a 16 x 18
// register file (r0 hardwired to zero), drives the ALU, captures its result
// and carry, then writes back and updates the sticky carry/zero flags.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus,
    output logic        done,
    output logic        err_illegal,
    output logic        carry_flag,
    output logic        zero_flag,
    input  logic [3:0]  dbg_addr,
    output logic [17:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [3:0] OPC_ADD  = 4'b0000;
    localparam logic [3:0] OPC_ADDI = 4'b0100;

    state_t      state_q, state_d;
    logic [17:0] instr_q;
    logic [17:0] r1_q, r2_q;
    logic [1:0]  op_q;
    logic [17:0] res_q;
    logic        cout_q;
    logic        err_q;
    logic        carry_q, zero_q;
    logic [17:0] rf_q [16];

    logic        accept;
    logic        legal_in;
    logic [3:0]  opc;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [17:0] src1_val;
    logic [17:0] src2_val;
    logic        is_add;

    // ALU select: ADDI reuses the adder, the four register ops map directly.
    function automatic logic [1:0] alu_sel(input logic [3:0] op);
        return (op == OPC_ADDI) ? 2'b00 : op[1:0];
    endfunction

    // Six-bit signed immediate widened to the datapath width.
    function automatic logic [17:0] sext6(input logic [5:0] imm);
        return {{12{imm[5]}}, imm};
    endfunction

    assign accept   = (state_q == S_IDLE) && bus.instr_valid;
    assign legal_in = (bus.instr[17:14] <= OPC_ADDI);

    assign opc    = instr_q[17:14];
    assign dst    = instr_q[13:10];
    assign src1   = instr_q[9:6];
    assign src2   = instr_q[5:2];
    assign is_add = (opc == OPC_ADD) || (opc == OPC_ADDI);

    assign src1_val = (src1 == 4'd0) ? 18'd0 : rf_q[src1];
    assign src2_val = (src2 == 4'd0) ? 18'd0 : rf_q[src2];

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_r1      = r1_q;
    assign bus.alu_r2      = r2_q;
    assign bus.alu_op_type = op_q;
    assign done            = (state_q == S_WB);
    assign err_illegal     = err_q;
    assign carry_flag      = carry_q;
    assign zero_flag       = zero_q;
    assign dbg_data        = (dbg_addr == 4'd0) ? 18'd0 : rf_q[dbg_addr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: illegal opcodes are consumed in IDLE without leaving it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && legal_in) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the instruction on handshake; flag illegal opcodes for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !legal_in;
            if (accept) instr_q <= bus.instr;
        end
    end

    // Operand and op-select registers, loaded only in READ and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q <= '0;
            r2_q <= '0;
            op_q <= 2'b00;
        end else if (state_q == S_READ) begin
            r1_q <= src1_val;
            r2_q <= (opc == OPC_ADDI) ? sext6(instr_q[5:0]) : src2_val;
            op_q <= alu_sel(opc);
        end
    end

    // Capture the combinational ALU output at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            cout_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            res_q  <= bus.alu_result;
            cout_q <= bus.alu_cout;
        end
    end

    // Register file writeback; writes aimed at r0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if ((state_q == S_WB) && (dst != 4'd0)) begin
            rf_q[dst] <= res_q;
        end
    end

    // Sticky flags: zero on every legal op, carry only on adder ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state_q == S_WB) begin
            zero_q <= (res_q == 18'd0);
            if (is_add) carry_q <= cout_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written
// corner sequences and randomized instructions against a behavioural model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        done, err_illegal, carry_flag, zero_flag;
    logic [3:0]  dbg_addr;
    logic [17:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_if bus ();

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .done        (done),
        .err_illegal (err_illegal),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Combinational ALU attached to the bus.
    logic [18:0] alu_sum;
    always_comb begin
        alu_sum      = {1'b0, bus.alu_r1} + {1'b0, bus.alu_r2};
        bus.alu_cout = alu_sum[18];
        case (bus.alu_op_type)
            2'b00:   bus.alu_result = alu_sum[17:0];
            2'b01:   bus.alu_result = bus.alu_r1 & bus.alu_r2;
            2'b10:   bus.alu_result = ~(bus.alu_r1 & bus.alu_r2);
            default: bus.alu_result = ~(bus.alu_r1 | bus.alu_r2);
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "timeout");
    end

    // Reference model state.
    logic [17:0] m_rf [16];
    logic        m_c, m_z;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [5:0] lo);
        return {op, d, s1, lo};
    endfunction

    // Expected ALU inputs and outcome of one legal instruction from the model.
    task automatic predict(input logic [17:0] ins, output logic [17:0] a, output logic [17:0] b,
                           output logic [1:0] op, output logic [17:0] res, output logic co);
        logic [3:0]  opc;
        logic [18:0] s;
        opc = ins[17:14];
        a   = m_rf[ins[9:6]];
        b   = (opc == 4'd4) ? 18'($signed(ins[5:0])) : m_rf[ins[5:2]];
        co  = 1'b0;
        case (opc)
            4'd0, 4'd4: begin op = 2'd0; s = {1'b0, a} + {1'b0, b}; res = s[17:0]; co = s[18]; end
            4'd1:       begin op = 2'd1; res = a & b; end
            4'd2:       begin op = 2'd2; res = ~(a & b); end
            default:    begin op = 2'd3; res = ~(a | b); end
        endcase
    endtask

    task automatic commit(input logic [17:0] ins, input logic [17:0] res, input logic co);
        if (ins[13:10] != 4'd0) m_rf[ins[13:10]] = res;
        m_z = (res == 18'd0);
        if (ins[17:14] == 4'd0 || ins[17:14] == 4'd4) m_c = co;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(bus.instr_ready), 32'd1);
    endtask

    // Issue one instruction and check the whole handshake/timing/result.
    task automatic run_instr(input logic [17:0] ins);
        logic [17:0] ea, eb, er;
        logic [1:0]  eo;
        logic        ec;
        wait_ready();
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);                 // cycle T+1
        bus.instr_valid = 1'b0;
        if (ins[17:14] > 4'd4) begin
            chk("ill_err_t1", 32'(err_illegal), 32'd1);
            chk("ill_ready_t1", 32'(bus.instr_ready), 32'd1);
            chk("ill_done_t1", 32'(done), 32'd0);
            @(negedge clk);
            chk("ill_err_t2", 32'(err_illegal), 32'd0);
            chk("ill_carry", 32'(carry_flag), 32'(m_c));
            chk("ill_zero", 32'(zero_flag), 32'(m_z));
            dbg_addr = ins[13:10];
            #1;
            chk("ill_dst_unchanged", 32'(dbg_data), 32'(m_rf[ins[13:10]]));
            return;
        end
        predict(ins, ea, eb, eo, er, ec);
        chk("t1_err", 32'(err_illegal), 32'd0);
        chk("t1_ready", 32'(bus.instr_ready), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        @(negedge clk);                 // cycle T+2 (EXEC)
        chk("alu_r1", 32'(bus.alu_r1), 32'(ea));
        chk("alu_r2", 32'(bus.alu_r2), 32'(eb));
        chk("alu_op", 32'(bus.alu_op_type), 32'(eo));
        chk("t2_done", 32'(done), 32'd0);
        @(negedge clk);                 // cycle T+3 (WB)
        chk("t3_done", 32'(done), 32'd1);
        @(negedge clk);                 // cycle T+4
        commit(ins, er, ec);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_ready", 32'(bus.instr_ready), 32'd1);
        dbg_addr = ins[13:10];
        #1;
        chk("wb_dst", 32'(dbg_data), 32'(m_rf[ins[13:10]]));
        chk("carry", 32'(carry_flag), 32'(m_c));
        chk("zero", 32'(zero_flag), 32'(m_z));
    endtask

    function automatic logic [17:0] rand_legal();
        logic [3:0] op;
        op = 4'($urandom_range(0, 4));
        return {op, 14'($urandom)};
    endfunction

    // instr_valid held high: one acceptance every four cycles, operand sequence checked.
    task automatic back_to_back(input int n);
        int cyc, last, chk_at, idx;
        bit need_new;
        logic [17:0] ins, pa, pb, er;
        logic [1:0]  po;
        logic        ec;
        cyc = 0; last = 0; chk_at = -1; idx = 0; need_new = 0;
        wait_ready();
        ins = rand_legal();
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        // ready was seen in this cycle; the edge ahead accepts it
        predict(ins, pa, pb, po, er, ec);
        commit(ins, er, ec);
        chk_at = 2; last = 0; idx = 1; need_new = 1;
        while ((idx < n || cyc < chk_at) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (need_new) begin
                ins = rand_legal();
                bus.instr = ins;
                need_new = 0;
                if (idx >= n) bus.instr_valid = 1'b0;
            end
            if (cyc == chk_at) begin
                chk("b2b_r1", 32'(bus.alu_r1), 32'(pa));
                chk("b2b_r2", 32'(bus.alu_r2), 32'(pb));
                chk("b2b_op", 32'(bus.alu_op_type), 32'(po));
            end
            if (bus.instr_ready && bus.instr_valid) begin
                chk("b2b_spacing", 32'(cyc - last), 32'd4);
                predict(ins, pa, pb, po, er, ec);
                commit(ins, er, ec);
                chk_at = cyc + 2;
                last = cyc;
                idx++;
                need_new = 1;
            end
        end
        bus.instr_valid = 1'b0;
        chk("b2b_budget", 32'(cyc < 200), 32'd1);
    endtask

    typedef struct {
        logic [17:0] ins;
        logic [3:0]  rd;
        logic [17:0] val;
        logic        c;
        logic        z;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{mk(4'd4, 4'd1, 4'd0, 6'd5),          4'd1, 18'h00005, 1'b0, 1'b0};
        tbl[1] = '{mk(4'd4, 4'd2, 4'd0, 6'h3F),         4'd2, 18'h3FFFF, 1'b0, 1'b0};
        tbl[2] = '{mk(4'd0, 4'd3, 4'd1, {4'd2, 2'b00}), 4'd3, 18'h00004, 1'b1, 1'b0};
        tbl[3] = '{mk(4'd1, 4'd4, 4'd1, {4'd2, 2'b00}), 4'd4, 18'h00005, 1'b1, 1'b0};
        tbl[4] = '{mk(4'd2, 4'd5, 4'd2, {4'd2, 2'b00}), 4'd5, 18'h00000, 1'b1, 1'b1};
        tbl[5] = '{mk(4'd3, 4'd6, 4'd0, {4'd0, 2'b00}), 4'd6, 18'h3FFFF, 1'b1, 1'b0};
        tbl[6] = '{mk(4'd4, 4'd0, 4'd0, 6'd3),          4'd0, 18'h00000, 1'b0, 1'b0};

        rst_n           = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        dbg_addr        = 4'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_r1", 32'(bus.alu_r1), 32'd0);
        chk("rst_r2", 32'(bus.alu_r2), 32'd0);
        chk("rst_op", 32'(bus.alu_op_type), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_flags", 32'({carry_flag, zero_flag}), 32'd0);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].ins);
            dbg_addr = tbl[i].rd;
            #1;
            chk("tbl_val", 32'(dbg_data), 32'(tbl[i].val));
            chk("tbl_carry", 32'(carry_flag), 32'(tbl[i].c));
            chk("tbl_zero", 32'(zero_flag), 32'(tbl[i].z));
        end

        // Illegal opcode 0111: pulse, no state change.
        run_instr({4'b0111, 4'd1, 4'd1, 4'd1, 2'b00});
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk("ill_rf", 32'(dbg_data), 32'(m_rf[i]));
        end

        back_to_back(8);

        repeat (40) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 7));
            run_instr({op, 14'($urandom)});
        end

        // Reset during EXEC of ADD r7,r1,r1 aborts without writeback.
        run_instr(mk(4'd4, 4'd1, 4'd0, 6'd9));
        wait_ready();
        bus.instr       = mk(4'd0, 4'd7, 4'd1, {4'd1, 2'b00});
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_ready", 32'(bus.instr_ready), 32'd1);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_flags", 32'({carry_flag, zero_flag}), 32'd0);
        chk("ar_r1", 32'(bus.alu_r1), 32'd0);
        dbg_addr = 4'd7;
        #1;
        chk("ar_r7", 32'(dbg_data), 32'd0);
        dbg_addr = 4'd1;
        #1;
        chk("ar_rf1", 32'(dbg_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_ready_after", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        chk("ar_r7_after", 32'({done, carry_flag, zero_flag}), 32'd0);

        run_instr(mk(4'd4, 4'd7, 4'd0, 6'h3E));
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk("final_rf", 32'(dbg_data), 32'(m_rf[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
